// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter
// N-way round-robin packet arbiter. It merges N upstream ready/valid streams
// into one downstream stream. A grant lasts for a whole packet, which ends on
// the beat that has last set. After each packet there is one idle cycle, and
// the arbiter re-arbitrates in that cycle.
//
// Optional feature macro: ARB_OUT_REG_EN
//   undefined : the output path is combinational from the granted requester,
//               so a beat reaches the downstream port in the same cycle.
//   defined   : the output comes from a 2-entry registered skid buffer.
//               Upstream ready is a registered not-full flag.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; searches ptr+1, ptr+2, ... for a valid requester
// GRANT | requester gnt owns the output until its last beat fires
module hs_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_valid,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic [IDW-1:0]     id_out,
    output logic               last_out,
    output logic               valid_down_out,
    input  logic               ready_down_in,
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // ptr resets to the last index, so requester 0 is searched first
    localparam logic [IDW-1:0] PTR_RST = IDW'(N - 1);

    state_t           state;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   pick_hi;
    logic [IDW-1:0]   pick_lo;
    logic             found_hi;
    logic             found_lo;
    logic             any_valid;
    logic             in_grant;
    logic             up_ready;
    logic             up_fire;
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;
    logic             sel_last;

    assign in_grant = (state == GRANT);
    assign busy     = in_grant;

    // Round-robin search. The lowest valid index above ptr wins. If there is
    // none, the search wraps and the lowest valid index at or below ptr wins.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDW'(i) > ptr) begin
                    pick_hi  = IDW'(i);
                    found_hi = 1'b1;
                end else begin
                    pick_lo  = IDW'(i);
                    found_lo = 1'b1;
                end
            end
        end
        any_valid = found_hi | found_lo;
        pick      = found_hi ? pick_hi : pick_lo;
    end

    // Select the granted requester's data, valid and last
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt == IDW'(i)) begin
                sel_data  = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Only the granted requester sees ready; everyone else is held off
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = in_grant && (gnt == IDW'(i)) && up_ready;
        end
    end

    assign up_fire = in_grant && sel_valid && up_ready;

    // Arbitration FSM: grant on a valid request; release on the last-beat fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= PTR_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt   <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (up_fire && sel_last) begin
                        ptr   <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_OUT_REG_EN
    logic [1:0]       count;
    logic [1:0]       count_nx;
    logic             not_full_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] e0_data;
    logic [WIDTH-1:0] e1_data;
    logic [IDW-1:0]   e0_id;
    logic [IDW-1:0]   e1_id;
    logic             e0_last;
    logic             e1_last;

    // Ready is registered so that upstream never sees a combinational path
    // from ready_down_in. The flag tracks the next occupancy.
    assign up_ready = not_full_q;
    assign push     = up_fire;
    assign pop      = (count != 2'd0) && ready_down_in;

    // Occupancy after this cycle's push and pop
    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + 2'd1;
        end else if (!push && pop) begin
            count_nx = count - 2'd1;
        end
    end

    // Skid buffer: e0 is the head entry, e1 holds the overflow beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            not_full_q <= 1'b1;
            e0_data    <= '0;
            e0_id      <= '0;
            e0_last    <= 1'b0;
            e1_data    <= '0;
            e1_id      <= '0;
            e1_last    <= 1'b0;
        end else begin
            count      <= count_nx;
            not_full_q <= (count_nx != 2'd2);
            if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                e0_data <= sel_data;
                e0_id   <= gnt;
                e0_last <= sel_last;
            end else if (push && (count == 2'd1)) begin
                e1_data <= sel_data;
                e1_id   <= gnt;
                e1_last <= sel_last;
            end else if (pop && (count == 2'd2)) begin
                e0_data <= e1_data;
                e0_id   <= e1_id;
                e0_last <= e1_last;
            end
        end
    end

    assign data_out       = e0_data;
    assign id_out         = e0_id;
    assign last_out       = e0_last;
    assign valid_down_out = (count != 2'd0);
`else
    // Zero-latency pass-through; outputs are forced to zero outside GRANT
    assign up_ready       = ready_down_in;
    assign valid_down_out = in_grant && sel_valid;
    assign data_out       = in_grant ? sel_data : '0;
    assign id_out         = in_grant ? gnt : '0;
    assign last_out       = in_grant && sel_last;
`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter
// Directed bench for hs_rr_arbiter (WIDTH=32, N=4). Inputs change on the
// falling edge. Outputs are checked 1 ns later, away from the rising edge.
// Building with ARB_OUT_REG_EN selects the registered-output expectations.
module tb_hs_rr_arbiter;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int IDW   = 2;

    logic               clk;
    logic               rst_n;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_last;
    logic [N-1:0]       req_ready;
    logic [WIDTH-1:0]   data_out;
    logic [IDW-1:0]     id_out;
    logic               last_out;
    logic               valid_down_out;
    logic               ready_down_in;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

    hs_rr_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .data_out       (data_out),
        .id_out         (id_out),
        .last_out       (last_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [WIDTH-1:0] v);
        req_data[i*WIDTH +: WIDTH] = v;
    endtask

    // Reset across two falling edges, then release on a falling edge
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy), 64'd0);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_valid"}, 64'(valid_down_out), 64'd0);
        check({tag, "_data"},  64'(data_out), 64'd0);
        check({tag, "_id"},    64'(id_out), 64'd0);
        check({tag, "_last"},  64'(last_out), 64'd0);
    endtask

    initial begin
        int exp_id;
        rst_n         = 1'b0;
        req_data      = '0;
        req_valid     = 4'hF;
        req_last      = 4'hF;
        ready_down_in = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, 32'hFFFF_0000 + 32'(i));
        #2;
        check_all_zero("reset");
        do_reset();

`ifndef ARB_OUT_REG_EN
        // Round robin between requesters 1 and 2, with a bubble after each packet
        req_valid = 4'b0110;
        req_last  = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 32'h0000_1000 + 32'(i));
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0) ? 1 : 2;
            @(negedge clk); #1;
            check("rr_id",    64'(id_out), 64'(exp_id));
            check("rr_ready", 64'(req_ready), 64'(1 << exp_id));
            check("rr_busy",  64'(busy), 64'd1);
            check("rr_data",  64'(data_out), 64'(32'h0000_1000 + 32'(exp_id)));
            @(negedge clk); #1;
            check("rr_bubble_busy",  64'(busy), 64'd0);
            check("rr_bubble_ready", 64'(req_ready), 64'd0);
        end

        // Requester 0 sends a 3-beat packet while requester 3 waits.
        // Beat 3 is preceded by a valid gap, which must not release the grant.
        do_reset();
        req_valid = 4'b1001;
        req_last  = 4'b1000;
        set_data(0, 32'h0000_00A0);
        set_data(3, 32'h0000_00D3);
        @(negedge clk); #1;
        check("pkt_b1_id",    64'(id_out), 64'd0);
        check("pkt_b1_data",  64'(data_out), 64'hA0);
        check("pkt_b1_last",  64'(last_out), 64'd0);
        check("pkt_b1_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        set_data(0, 32'h0000_00A1);
        #1;
        check("pkt_b2_id",    64'(id_out), 64'd0);
        check("pkt_b2_data",  64'(data_out), 64'hA1);
        check("pkt_b2_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        check("pkt_gap_busy",  64'(busy), 64'd1);
        check("pkt_gap_valid", 64'(valid_down_out), 64'd0);
        check("pkt_gap_id",    64'(id_out), 64'd0);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_last[0]  = 1'b1;
        set_data(0, 32'h0000_00A2);
        #1;
        check("pkt_b3_id",    64'(id_out), 64'd0);
        check("pkt_b3_data",  64'(data_out), 64'hA2);
        check("pkt_b3_last",  64'(last_out), 64'd1);
        check("pkt_b3_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        check("pkt_bubble_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        check("pkt_next_id",    64'(id_out), 64'd3);
        check("pkt_next_data",  64'(data_out), 64'hD3);
        check("pkt_next_ready", 64'(req_ready), 64'b1000);

        // Downstream stall on requester 2, then re-grant of the sole requester
        do_reset();
        ready_down_in = 1'b0;
        req_valid     = 4'b0100;
        req_last      = 4'hF;
        set_data(2, 32'hA5A5_A5A5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("stall_data",  64'(data_out), 64'hA5A5_A5A5);
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_valid", 64'(valid_down_out), 64'd1);
            check("stall_busy",  64'(busy), 64'd1);
        end
        @(negedge clk);
        ready_down_in = 1'b1;
        #1;
        check("stall_release_ready", 64'(req_ready), 64'b0100);
        @(negedge clk); #1;
        check("stall_bubble_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        check("solo_regrant_id",   64'(id_out), 64'd2);
        check("solo_regrant_busy", 64'(busy), 64'd1);

        // Reset in the middle of a packet from requester 1
        do_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        set_data(1, 32'h0000_00B1);
        @(negedge clk); #1;
        check("mid_id",   64'(id_out), 64'd1);
        check("mid_busy", 64'(busy), 64'd1);
        @(negedge clk); #1;
        check("mid_hold_id", 64'(id_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        req_valid = 4'hF;
        req_last  = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("after_reset_id",    64'(id_out), 64'd0);
        check("after_reset_ready", 64'(req_ready), 64'b0001);
`else
        // Requester 3 streams beats 0..7 through the skid buffer
        req_valid     = 4'b1000;
        req_last      = 4'b0000;
        ready_down_in = 1'b1;
        set_data(3, 32'd0);
        @(negedge clk); #1;
        check("str_first_ready", 64'(req_ready), 64'b1000);
        check("str_first_valid", 64'(valid_down_out), 64'd0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            set_data(3, 32'(k));
            req_last[3] = (k == 7);
            #1;
            check("str_valid", 64'(valid_down_out), 64'd1);
            check("str_data",  64'(data_out), 64'(k - 1));
            check("str_id",    64'(id_out), 64'd3);
            check("str_last",  64'(last_out), 64'd0);
            check("str_ready", 64'(req_ready), 64'b1000);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        check("str_end_data",  64'(data_out), 64'd7);
        check("str_end_last",  64'(last_out), 64'd1);
        check("str_end_valid", 64'(valid_down_out), 64'd1);
        check("str_end_busy",  64'(busy), 64'd0);
        @(negedge clk); #1;
        check("str_drained_valid", 64'(valid_down_out), 64'd0);

        // Stall with the buffer filling to two entries
        do_reset();
        ready_down_in = 1'b0;
        req_valid     = 4'b0100;
        req_last      = 4'b0000;
        set_data(2, 32'hA5A5_A5A5);
        @(negedge clk); #1;
        check("bstall_ready0", 64'(req_ready), 64'b0100);
        @(negedge clk);
        set_data(2, 32'h5A5A_5A5A);
        #1;
        check("bstall_ready1", 64'(req_ready), 64'b0100);
        check("bstall_data1",  64'(data_out), 64'hA5A5_A5A5);
        @(negedge clk);
        set_data(2, 32'hC3C3_C3C3);
        #1;
        check("bstall_full_ready", 64'(req_ready), 64'd0);
        check("bstall_full_busy",  64'(busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("bstall_hold_data",  64'(data_out), 64'hA5A5_A5A5);
            check("bstall_hold_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        ready_down_in = 1'b1;
        #1;
        check("bstall_pop_data", 64'(data_out), 64'hA5A5_A5A5);
        @(negedge clk); #1;
        check("bstall_second_data", 64'(data_out), 64'h5A5A_5A5A);
        check("bstall_ready_back",  64'(req_ready), 64'b0100);
        @(negedge clk); #1;
        check("bstall_third_data", 64'(data_out), 64'hC3C3_C3C3);
        rst_n = 1'b0;
        #1;
        check_all_zero("bmid_reset");
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
